jt12_timer_regs: RTL and testbench
==================================

Name: jt12_timer_regs

Overview:
- CPU-side register front end that writes and controls the YM2612 timer pair.
- Decodes the bus write sequence (latch an address, then write data) for registers 0x24–0x27 of part I.
- Drives the timer block's value, load, run, flag-clear and IRQ-enable inputs, and returns the status byte (busy, flag B, flag A) to the CPU.
- Sits between the bus glue and the timer block.

Parameters:
- BUSY_CYCLES, 32: clk cycles the busy bit stays high after a data write.
- BUSY_W, 6: width of the busy down-counter; must satisfy 2^BUSY_W > BUSY_CYCLES.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- cs_n  in  1  chip select, active-low
- wr_n  in  1  write strobe, active-low
- addr  in  2  bus address; addr[1] = part, addr[0] = 0 for address, 1 for data
- din  in  8  write data
- dout  out  8  status byte {busy, 5'b0, flag_B, flag_A}
- flag_A  in  1  timer A flag from the timer block
- flag_B  in  1  timer B flag from the timer block
- value_A  out  10  timer A start value NA
- value_B  out  8  timer B start value NB
- load_A  out  1  one-clk pulse that loads and starts timer A
- load_B  out  1  one-clk pulse that loads and starts timer B
- clr_run_A  out  1  one-clk pulse that stops timer A
- clr_run_B  out  1  one-clk pulse that stops timer B
- clr_flag_A  out  1  one-clk pulse that clears flag A
- clr_flag_B  out  1  one-clk pulse that clears flag B
- enable_irq_A  out  1  level; flag A may raise IRQ
- enable_irq_B  out  1  level; flag B may raise IRQ
- ch3_mode  out  2  register 0x27 bits [7:6], stored for the channel-3 logic

Behaviour:
- Reset: all outputs 0, latched address 0x00, latched part 0, busy counter 0, stored start bits 0.
- Reset overrides any write in the same cycle, and a reset during busy clears busy at the next edge.
- Bus sampling:
  - cs_n, wr_n, addr and din are registered once.
  - A write event is the first registered cycle in which (~cs_n & ~wr_n) holds after a cycle in which it did not.
  - A held strobe is one event only.
- Address write (addr[0]=0): latch din as the register address and addr[1] as the part. No busy, no other effect.
- Data write (addr[0]=1):
  - Always reloads the busy counter to BUSY_CYCLES, including writes to other registers, part II, or a write while busy.
  - Acts on timer state only if addr[1]=0 and the latched part is 0.
- Register map (part I):
  - 0x24: value_A[9:2] <= din.
  - 0x25: value_A[1:0] <= din[1:0].
  - 0x26: value_B <= din.
  - 0x27:
    - bit0 start A. On 0→1 versus the stored bit, pulse load_A. On 1→0, pulse clr_run_A. Unchanged: no pulse. Then store the bit.
    - bit1 start B: same rule, driving load_B / clr_run_B.
    - bit2 → enable_irq_A (level). bit3 → enable_irq_B (level).
    - bit4 = 1 pulses clr_flag_A. bit5 = 1 pulses clr_flag_B. Neither bit is stored.
    - bits[7:6] → ch3_mode.
  - Any other address: ignored apart from busy.
- Latency:
  - Value and level outputs update, and strobes assert, on the clk edge after the write event is detected. That is 2 clk after the edge where the bus strobe is first presented.
  - Strobes are high for exactly 1 clk.
- Value writes do not touch a running timer; the new value takes effect at the next load.
- A single 0x27 write may assert load_A, clr_flag_A, load_B and clr_flag_B in the same cycle. Flag clear and load are independent in the timer block.
- Busy:
  - The counter decrements once per clk while nonzero.
  - busy = (counter != 0). It goes high on the same edge the data write takes effect and lasts exactly BUSY_CYCLES clk.
- dout is registered every clk as {busy, 5'b0, flag_B, flag_A}, independent of cs_n, wr_n and addr; 1 clk latency from flag or busy changes.

Test Plan:
1. Reset, then write addr 0x24 data 0xFF, then addr 0x25 data 0x03 → value_A = 0x3FF; no strobes; busy high for exactly 32 clk after each data write; dout = 0x80 during busy, 0x00 after.
2. With the stored 0x27 value 0x00, write 0x27 data 0x05 → load_A one-clk pulse, enable_irq_A = 1, no clr_run_A. Write 0x05 again → no pulse. Write 0x04 → clr_run_A one-clk pulse.
3. Write 0x27 data 0x3B (stored start bits 00) → load_A, load_B, clr_flag_A, clr_flag_B all pulse in the same cycle; enable_irq_B = 1; enable_irq_A = 0; ch3_mode = 0.
4. Address write 0x26 with addr[1]=1, then data 0x80 with addr[1]=1 → value_B unchanged; busy still asserted for 32 clk.
5. Hold cs_n/wr_n low for 10 clk during a 0x27 data 0x01 write → exactly one load_A pulse. A second data write at busy count 5 → counter reloads; busy lasts 32 clk from the second write.
6. Drive flag_A = 1 and flag_B = 1 → dout = 0x03 one clk later. Assert rst mid-busy with a write pending → all outputs 0 at the next edge; the pending write is discarded.

Source files
------------

// File: rtl/jt12_timer_regs.sv
`default_nettype none
// ============================================================================
// Module      : jt12_timer_regs
// Description : CPU-side register front end for the YM2612 timer pair.
//               Decodes the address/data write sequence for part-I registers
//               0x24-0x27, drives the timer block controls and returns the
//               status byte {busy, 5'b0, flag_B, flag_A}.
// Revision    : 1.0 - initial release
// ============================================================================
module jt12_timer_regs #(
    parameter int BUSY_CYCLES = 32,
    parameter int BUSY_W      = 6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cs_n,
    input  logic       wr_n,
    input  logic [1:0] addr,
    input  logic [7:0] din,
    output logic [7:0] dout,
    input  logic       flag_A,
    input  logic       flag_B,
    output logic [9:0] value_A,
    output logic [7:0] value_B,
    output logic       load_A,
    output logic       load_B,
    output logic       clr_run_A,
    output logic       clr_run_B,
    output logic       clr_flag_A,
    output logic       clr_flag_B,
    output logic       enable_irq_A,
    output logic       enable_irq_B,
    output logic [1:0] ch3_mode
);

    localparam logic [7:0] c_REG_TA_HI = 8'h24;
    localparam logic [7:0] c_REG_TA_LO = 8'h25;
    localparam logic [7:0] c_REG_TB    = 8'h26;
    localparam logic [7:0] c_REG_CTRL  = 8'h27;

    // Bus sample stage
    logic       r_cs_n;
    logic       r_wr_n;
    logic [1:0] r_addr;
    logic [7:0] r_din;

    // Write-event stage
    logic       r_act_prev;
    logic       r_ev;
    logic [1:0] r_ev_addr;
    logic [7:0] r_ev_din;

    // Latched register address / part and stored start bits
    logic [7:0]        r_reg_addr;
    logic              r_part;
    logic              r_start_a;
    logic              r_start_b;
    logic [BUSY_W-1:0] r_busy_cnt;

    logic w_act;
    logic w_addr_wr;
    logic w_data_wr;
    logic w_data_p1;
    logic w_busy;

    assign w_act     = ~r_cs_n & ~r_wr_n;
    assign w_addr_wr = r_ev & ~r_ev_addr[0];
    assign w_data_wr = r_ev &  r_ev_addr[0];
    // Timer state is only touched when both the bus part and latched part are I
    assign w_data_p1 = w_data_wr & ~r_ev_addr[1] & ~r_part;
    assign w_busy    = (r_busy_cnt != '0);

    // Register the raw bus signals once; reset parks the strobes inactive
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cs_n <= 1'b1;
            r_wr_n <= 1'b1;
            r_addr <= '0;
            r_din  <= '0;
        end else begin
            r_cs_n <= cs_n;
            r_wr_n <= wr_n;
            r_addr <= addr;
            r_din  <= din;
        end
    end

    // Rising-edge detect of the registered strobe so a held strobe is one event
    always_ff @(posedge clk) begin
        if (rst) begin
            r_act_prev <= 1'b0;
            r_ev       <= 1'b0;
            r_ev_addr  <= '0;
            r_ev_din   <= '0;
        end else begin
            r_act_prev <= w_act;
            r_ev       <= w_act & ~r_act_prev;
            r_ev_addr  <= r_addr;
            r_ev_din   <= r_din;
        end
    end

    // Address phase: remember target register and part
    always_ff @(posedge clk) begin
        if (rst) begin
            r_reg_addr <= '0;
            r_part     <= 1'b0;
        end else if (w_addr_wr) begin
            r_reg_addr <= r_ev_din;
            r_part     <= r_ev_addr[1];
        end
    end

    // Busy counter: any data write reloads it, otherwise count down to zero
    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy_cnt <= '0;
        end else if (w_data_wr) begin
            r_busy_cnt <= BUSY_W'(BUSY_CYCLES);
        end else if (w_busy) begin
            r_busy_cnt <= r_busy_cnt - BUSY_W'(1);
        end
    end

    // Timer register file; strobes default low so each lasts one clk
    always_ff @(posedge clk) begin
        if (rst) begin
            value_A      <= '0;
            value_B      <= '0;
            load_A       <= 1'b0;
            load_B       <= 1'b0;
            clr_run_A    <= 1'b0;
            clr_run_B    <= 1'b0;
            clr_flag_A   <= 1'b0;
            clr_flag_B   <= 1'b0;
            enable_irq_A <= 1'b0;
            enable_irq_B <= 1'b0;
            ch3_mode     <= '0;
            r_start_a    <= 1'b0;
            r_start_b    <= 1'b0;
        end else begin
            load_A     <= 1'b0;
            load_B     <= 1'b0;
            clr_run_A  <= 1'b0;
            clr_run_B  <= 1'b0;
            clr_flag_A <= 1'b0;
            clr_flag_B <= 1'b0;
            if (w_data_p1) begin
                case (r_reg_addr)
                    c_REG_TA_HI: value_A[9:2] <= r_ev_din;
                    c_REG_TA_LO: value_A[1:0] <= r_ev_din[1:0];
                    c_REG_TB:    value_B      <= r_ev_din;
                    c_REG_CTRL: begin
                        // Start bits act on their transition versus the stored copy
                        load_A       <=  r_ev_din[0] & ~r_start_a;
                        clr_run_A    <= ~r_ev_din[0] &  r_start_a;
                        load_B       <=  r_ev_din[1] & ~r_start_b;
                        clr_run_B    <= ~r_ev_din[1] &  r_start_b;
                        r_start_a    <= r_ev_din[0];
                        r_start_b    <= r_ev_din[1];
                        enable_irq_A <= r_ev_din[2];
                        enable_irq_B <= r_ev_din[3];
                        clr_flag_A   <= r_ev_din[4];
                        clr_flag_B   <= r_ev_din[5];
                        ch3_mode     <= r_ev_din[7:6];
                    end
                    default: ;
                endcase
            end
        end
    end

    // Status byte, registered every clk regardless of bus activity
    always_ff @(posedge clk) begin
        if (rst) begin
            dout <= '0;
        end else begin
            dout <= {w_busy, 5'b0, flag_B, flag_A};
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_jt12_timer_regs.sv
`default_nettype none
// ============================================================================
// Module      : tb_jt12_timer_regs
// Description : Directed self-checking bench for jt12_timer_regs with an
//               expected-result queue filled at stimulus time.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_jt12_timer_regs;

    logic       clk = 1'b0;
    logic       rst;
    logic       cs_n;
    logic       wr_n;
    logic [1:0] addr;
    logic [7:0] din;
    logic [7:0] dout;
    logic       flag_A;
    logic       flag_B;
    logic [9:0] value_A;
    logic [7:0] value_B;
    logic       load_A, load_B, clr_run_A, clr_run_B, clr_flag_A, clr_flag_B;
    logic       enable_irq_A, enable_irq_B;
    logic [1:0] ch3_mode;

    jt12_timer_regs #(.BUSY_CYCLES(32), .BUSY_W(6)) dut (
        .clk(clk), .rst(rst), .cs_n(cs_n), .wr_n(wr_n), .addr(addr), .din(din),
        .dout(dout), .flag_A(flag_A), .flag_B(flag_B),
        .value_A(value_A), .value_B(value_B),
        .load_A(load_A), .load_B(load_B),
        .clr_run_A(clr_run_A), .clr_run_B(clr_run_B),
        .clr_flag_A(clr_flag_A), .clr_flag_B(clr_flag_B),
        .enable_irq_A(enable_irq_A), .enable_irq_B(enable_irq_B),
        .ch3_mode(ch3_mode)
    );

    always #5 clk = ~clk;

    // stb = {load_A, load_B, clr_run_A, clr_run_B, clr_flag_A, clr_flag_B}
    typedef struct packed {
        logic [9:0] va;
        logic [7:0] vb;
        logic [5:0] stb;
        logic [1:0] irq;
        logic [1:0] ch3;
    } obs_t;

    obs_t w_obs;
    assign w_obs = {value_A, value_B,
                    {load_A, load_B, clr_run_A, clr_run_B, clr_flag_A, clr_flag_B},
                    {enable_irq_A, enable_irq_B}, ch3_mode};

    int n_tests = 0;
    int n_fail  = 0;
    obs_t exp_q[$];

    // Strobe pulse counters for held-strobe and reset-discard checks
    int la_cnt = 0;
    int lb_cnt = 0;
    always @(negedge clk) begin
        la_cnt <= la_cnt + int'(load_A);
        lb_cnt <= lb_cnt + int'(load_B);
    end

    // Reference model state
    logic [7:0] m_addr;
    logic       m_part;
    logic [9:0] m_va;
    logic [7:0] m_vb;
    logic       m_sa, m_sb, m_ia, m_ib;
    logic [1:0] m_ch3;

    task automatic model_reset();
        m_addr = 8'h00; m_part = 1'b0; m_va = '0; m_vb = '0;
        m_sa = 1'b0; m_sb = 1'b0; m_ia = 1'b0; m_ib = 1'b0; m_ch3 = 2'b00;
    endtask

    task automatic model_apply(input logic part, input logic is_data,
                               input logic [7:0] d, output obs_t e);
        logic [5:0] stb;
        stb = '0;
        if (!is_data) begin
            m_addr = d;
            m_part = part;
        end else if (!part && !m_part) begin
            if (m_addr == 8'h24) m_va[9:2] = d;
            else if (m_addr == 8'h25) m_va[1:0] = d[1:0];
            else if (m_addr == 8'h26) m_vb = d;
            else if (m_addr == 8'h27) begin
                stb = {d[0] & !m_sa, d[1] & !m_sb, !d[0] & m_sa, !d[1] & m_sb, d[4], d[5]};
                m_sa = d[0]; m_sb = d[1];
                m_ia = d[2]; m_ib = d[3];
                m_ch3 = d[7:6];
            end
        end
        e = {m_va, m_vb, stb, {m_ia, m_ib}, m_ch3};
    endtask

    task automatic check_obs(input string tag, input obs_t got, input obs_t exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_int(input string tag, input int got, input int exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    // Present one bus cycle for `hold` clocks, starting and ending on a negedge
    task automatic drive(input logic part, input logic is_data,
                         input logic [7:0] d, input int hold);
        cs_n = 1'b0; wr_n = 1'b0; addr = {part, is_data}; din = d;
        repeat (hold) @(negedge clk);
        cs_n = 1'b1; wr_n = 1'b1;
    endtask

    // One-clk write; outputs are checked 3 negedges later (strobe) and 4 (settled)
    task automatic do_write(input logic part, input logic is_data,
                            input logic [7:0] d, input string tag);
        obs_t e;
        model_apply(part, is_data, d, e);
        exp_q.push_back(e);
        drive(part, is_data, d, 1);
        repeat (2) @(negedge clk);
        e = exp_q.pop_front();
        check_obs({tag, "_strobe"}, w_obs, e);
        @(negedge clk);
        e.stb = '0;
        check_obs({tag, "_after"}, w_obs, e);
    endtask

    // Called right after do_write of a data write: busy seen on dout for 32 clk
    task automatic measure_busy(input string tag);
        int n;
        n = 0;
        check_int({tag, "_dout_busy"}, int'(dout), 8'h80);
        while (dout[7] && n < 100) begin
            n++;
            @(negedge clk);
        end
        check_int({tag, "_busy_len"}, n, 32);
        check_int({tag, "_dout_idle"}, int'(dout), 8'h00);
    endtask

    initial begin
        obs_t e;
        int   c0;
        rst = 1'b1; cs_n = 1'b1; wr_n = 1'b1; addr = 2'b00; din = 8'h00;
        flag_A = 1'b0; flag_B = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        check_obs("reset_outputs", w_obs, '0);
        check_int("reset_dout", int'(dout), 0);
        rst = 1'b0;
        @(negedge clk);

        // 1: timer A value, busy per data write
        do_write(1'b0, 1'b0, 8'h24, "t1_addr24");
        do_write(1'b0, 1'b1, 8'hFF, "t1_data24");
        measure_busy("t1_w24");
        do_write(1'b0, 1'b0, 8'h25, "t1_addr25");
        do_write(1'b0, 1'b1, 8'h03, "t1_data25");
        measure_busy("t1_w25");
        check_int("t1_value_A", int'(value_A), 10'h3FF);

        // 2: start-bit transitions on timer A
        do_write(1'b0, 1'b0, 8'h27, "t2_addr27");
        do_write(1'b0, 1'b1, 8'h05, "t2_start");
        do_write(1'b0, 1'b1, 8'h05, "t2_same");
        do_write(1'b0, 1'b1, 8'h04, "t2_stop");

        // 3: all four strobes in one write
        do_write(1'b0, 1'b1, 8'h3B, "t3_multi");

        // 4: part-II write must not touch value_B
        do_write(1'b0, 1'b0, 8'h26, "t4_addr26");
        do_write(1'b0, 1'b1, 8'h55, "t4_data26");
        do_write(1'b1, 1'b0, 8'h26, "t4_addr26_p2");
        do_write(1'b1, 1'b1, 8'h80, "t4_data26_p2");
        measure_busy("t4_p2");
        check_int("t4_value_B", int'(value_B), 8'h55);

        // 5: held strobe gives one event; busy reload on second write
        do_write(1'b0, 1'b0, 8'h27, "t5_addr27");
        do_write(1'b0, 1'b1, 8'h00, "t5_clear");
        measure_busy("t5_clear");
        model_apply(1'b0, 1'b1, 8'h01, e);
        c0 = la_cnt;
        drive(1'b0, 1'b1, 8'h01, 10);
        e.stb = '0;
        check_obs("t5_held_values", w_obs, e);
        repeat (17) @(negedge clk);
        do_write(1'b0, 1'b1, 8'h01, "t5_reload");
        measure_busy("t5_reload");
        check_int("t5_load_A_pulses", la_cnt - c0, 1);

        // 6: flags on dout, then reset mid-busy with a pending write
        flag_A = 1'b1; flag_B = 1'b1;
        @(negedge clk);
        check_int("t6_dout_flags", int'(dout), 8'h03);
        do_write(1'b0, 1'b1, 8'h01, "t6_busy");
        check_int("t6_dout_busy_flags", int'(dout), 8'h83);
        c0 = lb_cnt;
        drive(1'b0, 1'b1, 8'h02, 1);
        rst = 1'b1;
        @(negedge clk);
        check_obs("t6_reset_outputs", w_obs, '0);
        check_int("t6_reset_dout", int'(dout), 0);
        rst = 1'b0; flag_A = 1'b0; flag_B = 1'b0;
        model_reset();
        repeat (4) @(negedge clk);
        check_int("t6_pending_discarded", lb_cnt - c0, 0);
        check_obs("t6_post_reset", w_obs, '0);
        check_int("t6_post_reset_dout", int'(dout), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
